// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 control path: opcodes, funct codes,
// FSM state encoding and datapath mux select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam logic [1:0] ASB_REG   = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_SHIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       sign_or_zero;
    logic       instr_done;
    logic       illegal;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_sig_t;

  // Logical immediates take a zero-extended operand, arithmetic ones sign-extended.
  function automatic logic imm_sign_extends(input logic [5:0] op);
    return !((op == OP_ANDI) || (op == OP_ORI));
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the shared
// datapath (slave).
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       alu_src_a;
  logic       sign_or_zero;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, alu_src_a, sign_or_zero, reg_dst, mem_to_reg,
           alu_src_b, alu_op, pc_src, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           reg_write, alu_src_a, sign_or_zero, reg_dst, mem_to_reg,
           alu_src_b, alu_op, pc_src, instr_done, illegal, state
  );
endinterface

// File: rtl/mips_mc_outdec.sv
// Output decoder for the multicycle controller: Moore strobes per state, with
// the memory-completion strobes gated by mem_ready. JAL/JR decode only when
// MIPS_MC_JAL_JR_EN is defined.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_sig_t  sig
);

  always_comb begin
    sig = '0;
    case (state)
      S_FETCH: begin
        sig.mem_read  = 1'b1;
        sig.alu_src_b = ASB_FOUR;
        sig.ir_write  = mem_ready;
        sig.pc_write  = mem_ready;
      end
      S_DECODE: sig.alu_src_b = ASB_SHIMM;
      S_MEMADR: begin
        sig.alu_src_a    = 1'b1;
        sig.alu_src_b    = ASB_IMM;
        sig.sign_or_zero = 1'b1;
      end
      S_MEMRD: begin
        sig.mem_read = 1'b1;
        sig.iord     = 1'b1;
      end
      S_MEMWB: begin
        sig.reg_write  = 1'b1;
        sig.reg_dst    = RD_RT;
        sig.mem_to_reg = MTR_MEM;
        sig.instr_done = 1'b1;
      end
      // A store only finishes on the cycle memory accepts it.
      S_MEMWR: begin
        sig.mem_write  = 1'b1;
        sig.iord       = 1'b1;
        sig.instr_done = mem_ready;
      end
      S_RTEXEC: begin
        sig.alu_src_a = 1'b1;
        sig.alu_src_b = ASB_REG;
        sig.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        sig.reg_write  = 1'b1;
        sig.reg_dst    = RD_RD;
        sig.mem_to_reg = MTR_ALU;
        sig.instr_done = 1'b1;
      end
      S_IMMEX: begin
        sig.alu_src_a    = 1'b1;
        sig.alu_src_b    = ASB_IMM;
        sig.alu_op       = ALU_IMM;
        sig.sign_or_zero = imm_sign_extends(opcode);
      end
      S_IMMWB: begin
        sig.reg_write  = 1'b1;
        sig.reg_dst    = RD_RT;
        sig.instr_done = 1'b1;
      end
      S_BRANCH: begin
        sig.alu_src_a     = 1'b1;
        sig.alu_op        = ALU_SUB;
        sig.pc_write_cond = 1'b1;
        sig.pc_src        = PC_ALUOUT;
        sig.instr_done    = 1'b1;
      end
      S_JUMP: begin
        sig.pc_write   = 1'b1;
        sig.pc_src     = PC_JUMP;
        sig.instr_done = 1'b1;
      end
`ifdef MIPS_MC_JAL_JR_EN
      S_JAL: begin
        sig.pc_write   = 1'b1;
        sig.pc_src     = PC_JUMP;
        sig.reg_write  = 1'b1;
        sig.reg_dst    = RD_RA;
        sig.mem_to_reg = MTR_PC;
        sig.instr_done = 1'b1;
      end
      S_JR: begin
        sig.pc_write   = 1'b1;
        sig.pc_src     = PC_REG;
        sig.instr_done = 1'b1;
      end
`endif
      S_TRAP:  sig.illegal = 1'b1;
      default: sig = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS32 control FSM: state register and next-state sequencing over
// the shared datapath. MIPS_MC_JAL_JR_EN adds the JAL and JR instruction flows.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mips_mc_ctrl_if.master bus
);

  state_e    state_q;
  state_e    state_d;
  ctrl_sig_t sig;

  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_e nxt;
    nxt = S_TRAP;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
`ifdef MIPS_MC_JAL_JR_EN
      OP_RTYPE: nxt = (fn == FN_JR) ? S_JR : S_RTEXEC;
      OP_JAL:   nxt = S_JAL;
`else
      OP_RTYPE: nxt = (fn == FN_JR) ? S_TRAP : S_RTEXEC;
`endif
      OP_BEQ:   nxt = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IMMEX;
      OP_J:     nxt = S_JUMP;
      default:  nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Memory states stall on mem_ready; TRAP only leaves through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(bus.opcode, bus.funct);
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_RTEXEC: state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MIPS_MC_JAL_JR_EN
      S_JAL, S_JR: state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  mips_mc_outdec u_outdec (
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .sig       (sig)
  );

  assign bus.pc_write      = sig.pc_write;
  assign bus.pc_write_cond = sig.pc_write_cond;
  assign bus.ir_write      = sig.ir_write;
  assign bus.iord          = sig.iord;
  assign bus.mem_read      = sig.mem_read;
  assign bus.mem_write     = sig.mem_write;
  assign bus.reg_write     = sig.reg_write;
  assign bus.alu_src_a     = sig.alu_src_a;
  assign bus.sign_or_zero  = sig.sign_or_zero;
  assign bus.reg_dst       = sig.reg_dst;
  assign bus.mem_to_reg    = sig.mem_to_reg;
  assign bus.alu_src_b     = sig.alu_src_b;
  assign bus.alu_op        = sig.alu_op;
  assign bus.pc_src        = sig.pc_src;
  assign bus.instr_done    = sig.instr_done;
  assign bus.illegal       = sig.illegal;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed per-cycle expectations are queued
// by the stimulus thread and compared by an independent negedge monitor.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  typedef struct {
    string       tag;
    state_e      st;
    logic [10:0] strb;
    logic [9:0]  sl;
  } exp_t;

  // Strobe vector: pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
  // reg_write, alu_src_a, sign_or_zero, instr_done, illegal.
  localparam logic [10:0] B_PCW  = 11'h400;
  localparam logic [10:0] B_PWC  = 11'h200;
  localparam logic [10:0] B_IRW  = 11'h100;
  localparam logic [10:0] B_IORD = 11'h080;
  localparam logic [10:0] B_MRD  = 11'h040;
  localparam logic [10:0] B_MWR  = 11'h020;
  localparam logic [10:0] B_RW   = 11'h010;
  localparam logic [10:0] B_ALUA = 11'h008;
  localparam logic [10:0] B_SOZ  = 11'h004;
  localparam logic [10:0] B_DONE = 11'h002;
  localparam logic [10:0] B_ILL  = 11'h001;
  localparam logic [10:0] B_NONE = 11'h000;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Select vector: reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src.
  function automatic logic [9:0] sel(input int rd, input int mtr, input int asb,
                                     input int aop, input int pcs);
    return {rd[1:0], mtr[1:0], asb[1:0], aop[1:0], pcs[1:0]};
  endfunction

  task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                input logic rdy, input state_e st, input logic [10:0] strb,
                                input logic [9:0] sl);
    exp_t e;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = rdy;
    e.tag  = tag;
    e.st   = st;
    e.strb = strb;
    e.sl   = sl;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // mem_ready is driven low in DECODE to show it is ignored there.
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    apply_stimulus({tag, "_fetch"}, op, fn, 1'b1, S_FETCH, B_PCW | B_IRW | B_MRD, sel(0, 0, 1, 0, 0));
    apply_stimulus({tag, "_decode"}, op, fn, 1'b0, S_DECODE, B_NONE, sel(0, 0, 3, 0, 0));
  endtask

  task automatic check_output(input exp_t e);
    logic [10:0] strb;
    logic [9:0]  sl;
    strb = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.reg_write, bus.alu_src_a, bus.sign_or_zero,
            bus.instr_done, bus.illegal};
    sl   = {bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op, bus.pc_src};
    checks++;
    if (bus.state !== e.st || strb !== e.strb || sl !== e.sl) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d strobes=%b sel=%b, expected state=%0d strobes=%b sel=%b",
               e.tag, bus.state, strb, sl, e.st, e.strb, e.sl);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) check_output(sb.pop_front());
    end
  end

  initial begin
    reset         = 1'b0;
    bus.opcode    = OP_LW;
    bus.funct     = 6'd0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus("reset", OP_LW, 6'd0, 1'b1, S_FETCH, B_PCW | B_IRW | B_MRD, sel(0, 0, 1, 0, 0));
    reset = 1'b1;

    fetch_decode("lw", OP_LW, 6'd0);
    apply_stimulus("lw_memadr", OP_LW, 6'd0, 1'b0, S_MEMADR, B_ALUA | B_SOZ, sel(0, 0, 2, 0, 0));
    apply_stimulus("lw_memrd", OP_LW, 6'd0, 1'b1, S_MEMRD, B_IORD | B_MRD, sel(0, 0, 0, 0, 0));
    apply_stimulus("lw_memwb", OP_LW, 6'd0, 1'b1, S_MEMWB, B_RW | B_DONE, sel(0, 1, 0, 0, 0));

    fetch_decode("sw", OP_SW, 6'd0);
    apply_stimulus("sw_memadr", OP_SW, 6'd0, 1'b1, S_MEMADR, B_ALUA | B_SOZ, sel(0, 0, 2, 0, 0));
    for (int i = 0; i < 3; i++)
      apply_stimulus("sw_memwr_wait", OP_SW, 6'd0, 1'b0, S_MEMWR, B_IORD | B_MWR, sel(0, 0, 0, 0, 0));
    apply_stimulus("sw_memwr_done", OP_SW, 6'd0, 1'b1, S_MEMWR, B_IORD | B_MWR | B_DONE, sel(0, 0, 0, 0, 0));

    for (int i = 0; i < 2; i++)
      apply_stimulus("add_fetch_wait", OP_RTYPE, 6'b100000, 1'b0, S_FETCH, B_MRD, sel(0, 0, 1, 0, 0));
    fetch_decode("add", OP_RTYPE, 6'b100000);
    apply_stimulus("add_rtexec", OP_RTYPE, 6'b100000, 1'b1, S_RTEXEC, B_ALUA, sel(0, 0, 0, 2, 0));
    apply_stimulus("add_aluwb", OP_RTYPE, 6'b100000, 1'b1, S_ALUWB, B_RW | B_DONE, sel(1, 0, 0, 0, 0));

    fetch_decode("lw2", OP_LW, 6'd0);
    apply_stimulus("lw2_memadr", OP_LW, 6'd0, 1'b1, S_MEMADR, B_ALUA | B_SOZ, sel(0, 0, 2, 0, 0));
    apply_stimulus("lw2_memrd_wait", OP_LW, 6'd0, 1'b0, S_MEMRD, B_IORD | B_MRD, sel(0, 0, 0, 0, 0));
    apply_stimulus("lw2_memrd", OP_LW, 6'd0, 1'b1, S_MEMRD, B_IORD | B_MRD, sel(0, 0, 0, 0, 0));
    apply_stimulus("lw2_memwb", OP_LW, 6'd0, 1'b0, S_MEMWB, B_RW | B_DONE, sel(0, 1, 0, 0, 0));

    fetch_decode("beq", OP_BEQ, 6'd0);
    apply_stimulus("beq_branch", OP_BEQ, 6'd0, 1'b1, S_BRANCH, B_ALUA | B_PWC | B_DONE, sel(0, 0, 0, 1, 1));

    fetch_decode("ori", OP_ORI, 6'd0);
    apply_stimulus("ori_immex", OP_ORI, 6'd0, 1'b1, S_IMMEX, B_ALUA, sel(0, 0, 2, 3, 0));
    apply_stimulus("ori_immwb", OP_ORI, 6'd0, 1'b1, S_IMMWB, B_RW | B_DONE, sel(0, 0, 0, 0, 0));

    fetch_decode("addi", OP_ADDI, 6'd0);
    apply_stimulus("addi_immex", OP_ADDI, 6'd0, 1'b0, S_IMMEX, B_ALUA | B_SOZ, sel(0, 0, 2, 3, 0));
    apply_stimulus("addi_immwb", OP_ADDI, 6'd0, 1'b0, S_IMMWB, B_RW | B_DONE, sel(0, 0, 0, 0, 0));

    fetch_decode("j", OP_J, 6'd0);
    apply_stimulus("j_jump", OP_J, 6'd0, 1'b1, S_JUMP, B_PCW | B_DONE, sel(0, 0, 0, 0, 2));

    fetch_decode("sw2", OP_SW, 6'd0);
    apply_stimulus("sw2_memadr", OP_SW, 6'd0, 1'b0, S_MEMADR, B_ALUA | B_SOZ, sel(0, 0, 2, 0, 0));
    apply_stimulus("sw2_memwr", OP_SW, 6'd0, 1'b0, S_MEMWR, B_IORD | B_MWR, sel(0, 0, 0, 0, 0));
    reset = 1'b0;
    apply_stimulus("sw2_abort", OP_SW, 6'd0, 1'b0, S_FETCH, B_MRD, sel(0, 0, 1, 0, 0));
    reset = 1'b1;

`ifdef MIPS_MC_JAL_JR_EN
    fetch_decode("jal", OP_JAL, 6'd0);
    apply_stimulus("jal_jal", OP_JAL, 6'd0, 1'b1, S_JAL, B_PCW | B_RW | B_DONE, sel(2, 2, 0, 0, 2));
    fetch_decode("jr", OP_RTYPE, FN_JR);
    apply_stimulus("jr_jr", OP_RTYPE, FN_JR, 1'b1, S_JR, B_PCW | B_DONE, sel(0, 0, 0, 0, 3));
`else
    fetch_decode("jal", OP_JAL, 6'd0);
    for (int i = 0; i < 10; i++)
      apply_stimulus("jal_trap", OP_JAL, 6'd0, i[0], S_TRAP, B_ILL, sel(0, 0, 0, 0, 0));
    reset = 1'b0;
    apply_stimulus("jal_trap_reset", OP_JAL, 6'd0, 1'b1, S_FETCH, B_PCW | B_IRW | B_MRD, sel(0, 0, 1, 0, 0));
    reset = 1'b1;
    fetch_decode("jr", OP_RTYPE, FN_JR);
    apply_stimulus("jr_trap", OP_RTYPE, FN_JR, 1'b1, S_TRAP, B_ILL, sel(0, 0, 0, 0, 0));
    reset = 1'b0;
    apply_stimulus("jr_trap_reset", OP_RTYPE, FN_JR, 1'b0, S_FETCH, B_MRD, sel(0, 0, 1, 0, 0));
    reset = 1'b1;
`endif

    fetch_decode("bad", 6'b111111, 6'd0);
    for (int i = 0; i < 3; i++)
      apply_stimulus("bad_trap", 6'b111111, 6'd0, 1'b1, S_TRAP, B_ILL, sel(0, 0, 0, 0, 0));
    reset = 1'b0;
    apply_stimulus("bad_trap_reset", 6'b111111, 6'd0, 1'b1, S_FETCH, B_PCW | B_IRW | B_MRD, sel(0, 0, 1, 0, 0));
    reset = 1'b1;
    fetch_decode("recover", OP_BEQ, 6'd0);
    apply_stimulus("recover_branch", OP_BEQ, 6'd0, 1'b0, S_BRANCH, B_ALUA | B_PWC | B_DONE, sel(0, 0, 0, 1, 1));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
